// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the UART receive path (trigger levels, LSR bits, FIFO entry layout)
package uart_pkg;
  typedef enum logic [1:0] {TRIG_1 = 2'd0, TRIG_4 = 2'd1, TRIG_8 = 2'd2, TRIG_14 = 2'd3} trig_lvl_e;
  localparam int ENT_W = 11;
  localparam int ENT_PE = 8;
  localparam int ENT_FE = 9;
  localparam int ENT_BI = 10;
  localparam int LSR_DR = 0;
  localparam int LSR_OE = 1;
  localparam int LSR_PE = 2;
  localparam int LSR_FE = 3;
  localparam int LSR_BI = 4;
  localparam int LSR_FIFOERR = 7;
  function automatic int trig_level(input logic [1:0] lvl);
    return lvl == TRIG_1 ? 1 : lvl == TRIG_4 ? 4 : lvl == TRIG_8 ? 8 : 14;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: entry storage with one write port and an asynchronous read port
module uart_rx_fifo_mem import uart_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ENT_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ENT_W-1:0]  rdata
);
  logic [ENT_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: RX character FIFO presenting the head entry as RBR/LSR plus trigger and timeout flags
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              bclk_in,
  input  logic              rst_in,
  input  logic              fifo_en_in,
  input  logic              clr_in,
  input  logic [1:0]        trig_lvl_in,
  input  logic              wr_valid_in,
  input  logic [7:0]        wr_data_in,
  input  logic              wr_pe_in,
  input  logic              wr_fe_in,
  input  logic              wr_bi_in,
  input  logic              rd_in,
  input  logic              lsr_rd_in,
  input  logic              char_tick_in,
  output logic [7:0]        rd_data_out,
  output logic              lsr_dr_out,
  output logic              lsr_oe_out,
  output logic              lsr_pe_out,
  output logic              lsr_fe_out,
  output logic              lsr_bi_out,
  output logic              lsr_fifoerr_out,
  output logic              trig_out,
  output logic              timeout_out,
  output logic [ADDR_W:0]   count_out
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] count, err_cnt;
  logic [2:0] tcnt;
  logic [ENT_W-1:0] head;
  logic oe, fifo_en_q, empty, flush, full, rd_do, wr_do, overrun, wr_err, rd_err;
  uart_rx_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(bclk_in),
    .we(wr_do),
    .waddr(wr_ptr),
    .wdata({wr_bi_in, wr_fe_in, wr_pe_in, wr_data_in}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // a mode change flushes just like clr_in; single-entry mode caps occupancy at one
  always_comb begin
    empty = count == '0;
    flush = clr_in || (fifo_en_in != fifo_en_q);
    full = fifo_en_in ? count == FULL_CNT : !empty;
    rd_do = rd_in && !empty && !flush;
    wr_do = wr_valid_in && !flush && (!full || rd_do);
    overrun = wr_valid_in && !flush && full && !rd_in;
    wr_err = wr_do && (wr_pe_in || wr_fe_in || wr_bi_in);
    rd_err = rd_do && |head[ENT_BI:ENT_PE];
  end
  always_ff @(posedge bclk_in) begin
    fifo_en_q <= fifo_en_in;
    if (rst_in || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_cnt <= '0;
      tcnt <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(wr_do) - (ADDR_W+1)'(rd_do);
      err_cnt <= err_cnt + (ADDR_W+1)'(wr_err) - (ADDR_W+1)'(rd_err);
      tcnt <= (wr_do || rd_in || empty || !fifo_en_in) ? 3'd0 :
              (char_tick_in && tcnt != 3'd4) ? tcnt + 3'd1 : tcnt;
    end
    if (rst_in) oe <= 1'b0;
    else if (overrun) oe <= 1'b1;
    else if (lsr_rd_in) oe <= 1'b0;
  end
  assign rd_data_out = empty ? '0 : head[7:0];
  assign lsr_pe_out = !empty && head[ENT_PE];
  assign lsr_fe_out = !empty && head[ENT_FE];
  assign lsr_bi_out = !empty && head[ENT_BI];
  assign lsr_dr_out = !empty;
  assign lsr_oe_out = oe;
  assign lsr_fifoerr_out = fifo_en_in && err_cnt != '0;
  assign trig_out = fifo_en_in ? int'(count) >= trig_level(trig_lvl_in) : !empty;
  assign timeout_out = tcnt == 3'd4 && !empty;
  assign count_out = count;
endmodule
